mac_drain_requant: RTL and testbench
====================================

# mac_drain_requant

Downstream drain stage for a row of `LANES` MAC accumulators. On a capture request it snapshots every 32-bit accumulator and asserts an acknowledge so the MAC row is cleared. It then streams the lanes out one per handshake, each requantized to signed 8-bit by a rounding arithmetic right shift with saturation. It sits between the MAC array and the result writeback / output FIFO.

## Interface
- `LANES`, 8, number of accumulator lanes drained per capture (≥2)
- `ACC_W`, 32, accumulator width (two's complement)
- `OUT_W`, 8, requantized output width (two's complement)
- `clk` in 1: single clock, all state on rising edge
- `rst` in 1: synchronous, active-high reset
- `cap_i` in 1: capture request
- `shift_i` in 5: right-shift amount, latched at capture
- `acc_i` in LANES*ACC_W: accumulator values, lane k at bits [k*ACC_W +: ACC_W]
- `cap_ack_o` out 1: combinational; capture accepted this cycle; drives the MAC row `rst`
- `busy_o` out 1: in DRAIN state
- `out_valid_o` out 1: output beat valid
- `out_ready_i` in 1: consumer ready
- `out_data_o` out OUT_W: requantized lane value
- `out_idx_o` out $clog2(LANES): lane index of current beat
- `out_last_o` out 1: current beat is lane LANES-1
- `out_sat_o` out 1: current beat was saturated

## Operation
- FSM states: IDLE, DRAIN.
- Accept condition: `cap_i && (state==IDLE || (out_valid_o && out_ready_i && out_last_o))`. `cap_ack_o` equals this condition.
- On accept:
  - latch all lanes of `acc_i` into the bank
  - latch `shift_i`
  - load the output register with lane 0 computed directly from `acc_i`
  - idx←0, state←DRAIN
- `cap_i` in DRAIN outside the last-handshake cycle: ignored; `cap_ack_o`=0; bank unchanged.
- Handshake (`out_valid_o && out_ready_i`), not last: idx←idx+1; output register←requant(bank[idx+1]).
- Handshake on last with no accept: state←IDLE; `out_valid_o`←0.
- Handshake on last with a simultaneous accept: stays in DRAIN; lane 0 of the new capture is presented next cycle.
- When `out_valid_o && !out_ready_i`: data, idx, last and sat are held stable.
- Requant(x, s):
  - sign-extend x to ACC_W+1
  - add r = (s==0) ? 0 : 1<<(s-1)
  - arithmetic shift right by s
  - saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; `out_sat_o`=1 iff clamped
- Rounding is round-half-up toward +inf. The extra bit prevents overflow of the rounding add.

## Timing
- Reset values:
  - state IDLE, idx 0
  - `out_valid_o`, `out_data_o`, `out_idx_o`, `out_last_o`, `out_sat_o`, `busy_o` all 0
  - `cap_ack_o` is 0 while `cap_i`=0
- Reset mid-drain: next cycle IDLE with all outputs 0. The bank content is don't-care.
- Latency: accept at edge T → `out_valid_o`=1 with lane 0 in cycle T+1.
- Throughput: one lane per cycle while `out_ready_i`=1. Back-to-back captures give one capture per LANES cycles with no bubble.
- `cap_ack_o` is combinational from `cap_i`, state and the handshake. The MAC product presented in the accept cycle is discarded by the MAC reset; upstream must not issue operands in that cycle.

## Structure
- Package `mac_pkg`:
  - `ACC_W`, `OUT_W` constants
  - `drain_state_e` enum {IDLE, DRAIN}
  - `acc_t`, `q_t` typedefs
- Sub-module `requant_sat`: combinational; inputs acc_t x and 5-bit shift; outputs q_t value and sat flag. Two instances:
  - one on `acc_i[lane 0]` for capture
  - one on bank[idx+1] for advance

## Test plan
- shift 0, acc = {0,1,-1,127,128,-129,-128,1000}, ready=1 → data {0,1,-1,127,127,-128,-128,127}, sat {0,0,0,0,1,1,0,1}, `out_last_o` only on idx 7, valid 8 consecutive cycles.
- shift 4: acc 24→2, -24→-1, 8→1, 7→0. Also shift 31 with acc 0x7FFFFFFF→1 (no overflow).
- Backpressure: ready low for 3 cycles while idx=2 → data, idx and sat held. Resumes at lane 3, total 11 cycles.
- `cap_i` held high during DRAIN → `cap_ack_o`=0 until the last-handshake cycle, then 1. Next cycle shows idx 0 with the new data, valid never drops.
- `rst` asserted at idx 4 → next cycle valid 0, idx 0, busy 0. A subsequent capture drains all 8 lanes correctly.
- Capture while idle with ready=0 for 5 cycles → lane 0 is held; `cap_ack_o`=0 for any `cap_i` in that window.

Source files
------------

// File: rtl/mac_drain_requant_pkg.sv
// Shared types and constants for the MAC drain / requantization stage.
package mac_pkg;

    localparam int ACC_W = 32;  // accumulator width, two's complement
    localparam int OUT_W = 8;   // requantized output width, two's complement

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } drain_state_e;

    typedef logic signed [ACC_W-1:0] acc_t;
    typedef logic signed [OUT_W-1:0] q_t;

endpackage

// File: rtl/mac_drain_requant_if.sv
// Capture and output-stream signals of the drain stage. The producer/consumer
// side uses the master modport, the drain stage itself the slave modport.
interface mac_drain_requant_if
    import mac_pkg::*;
#(
    parameter int LANES = 8
);
    localparam int IDX_W = $clog2(LANES);

    // Capture side
    logic                     cap_i;
    logic [4:0]               shift_i;
    logic [LANES*ACC_W-1:0]   acc_i;
    logic                     cap_ack_o;
    logic                     busy_o;

    // Output stream
    logic                     out_valid_o;
    logic                     out_ready_i;
    q_t                       out_data_o;
    logic [IDX_W-1:0]         out_idx_o;
    logic                     out_last_o;
    logic                     out_sat_o;

    modport master (
        output cap_i, shift_i, acc_i, out_ready_i,
        input  cap_ack_o, busy_o, out_valid_o, out_data_o, out_idx_o,
               out_last_o, out_sat_o
    );

    modport slave (
        input  cap_i, shift_i, acc_i, out_ready_i,
        output cap_ack_o, busy_o, out_valid_o, out_data_o, out_idx_o,
               out_last_o, out_sat_o
    );

endinterface

// File: rtl/mac_drain_requant_requant_sat.sv
// Combinational requantizer: rounding (half-up) arithmetic right shift of a
// 32-bit accumulator followed by saturation to the signed output range.
module requant_sat
    import mac_pkg::*;
(
    input  acc_t       x,
    input  logic [4:0] shift,
    output q_t         value,
    output logic       sat
);
    // One guard bit so that adding the rounding constant can never overflow.
    localparam logic signed [ACC_W:0] Q_MAX = (ACC_W+1)'((1 << (OUT_W-1)) - 1);
    localparam logic signed [ACC_W:0] Q_MIN = -Q_MAX - (ACC_W+1)'(1);

    logic signed [ACC_W:0] ext;
    logic signed [ACC_W:0] rnd;
    logic signed [ACC_W:0] sum;
    logic signed [ACC_W:0] shifted;

    // Round, shift, then clamp into the output range.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        value   = '0;
        sat     = 1'b0;
        ext     = {x[ACC_W-1], x};
        rnd     = (shift == 5'd0) ? '0 : ((ACC_W+1)'(1) << (shift - 5'd1));
        sum     = ext + rnd;
        shifted = sum >>> shift;
        if (shifted > Q_MAX) begin
            value = Q_MAX[OUT_W-1:0];
            sat   = 1'b1;
        end else if (shifted < Q_MIN) begin
            value = Q_MIN[OUT_W-1:0];
            sat   = 1'b1;
        end else begin
            value = shifted[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/mac_drain_requant.sv
// Drain stage for a row of MAC accumulators: snapshots all lanes on capture,
// acknowledges so the MAC row clears, then streams requantized lanes out one
// per handshake. A capture may overlap the final handshake of a drain, so
// back-to-back captures stream without a bubble.
module mac_drain_requant
    import mac_pkg::*;
#(
    parameter int LANES = 8
)(
    input  logic                clk,
    input  logic                rst,
    mac_drain_requant_if.slave  bus
);
    localparam int IDX_W = $clog2(LANES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

    drain_state_e     state_q, state_d;
    acc_t             bank_q [LANES];
    logic [4:0]       shift_q;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_p1;
    q_t               data_q;
    logic             last_q;
    logic             sat_q;

    logic             out_valid;
    logic             handshake;
    logic             accept;

    q_t               cap_value, adv_value;
    logic             cap_sat, adv_sat;

    assign out_valid = (state_q == DRAIN);
    assign handshake = out_valid && bus.out_ready_i;

    // Wraps explicitly so a non-power-of-two LANES never indexes past the bank.
    assign idx_p1 = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);

    // Lane 0 of a new capture is taken straight from the live accumulators.
    requant_sat u_requant_cap (
        .x     (bus.acc_i[ACC_W-1:0]),
        .shift (bus.shift_i),
        .value (cap_value),
        .sat   (cap_sat)
    );

    // Following lanes come from the snapshot with the latched shift.
    requant_sat u_requant_adv (
        .x     (bank_q[idx_p1]),
        .shift (shift_q),
        .value (adv_value),
        .sat   (adv_sat)
    );

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state and capture accept; a capture is only taken when idle or
    // on the handshake of the last lane.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.cap_i) begin
                    accept  = 1'b1;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (handshake && last_q) begin
                    if (bus.cap_i) accept  = 1'b1;
                    else           state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Accumulator snapshot and shift amount, written only on accept.
    always_ff @(posedge clk) begin
        // NOTE: the bank is not reset; it is always rewritten by the capture
        // that makes its contents visible, so reset would only cost flops.
        if (accept) begin
            shift_q <= bus.shift_i;
            for (int k = 0; k < LANES; k++) begin
                bank_q[k] <= bus.acc_i[k*ACC_W +: ACC_W];
            end
        end
    end

    // Output beat register: load lane 0 on accept, advance on handshake,
    // clear after the last lane leaves, hold under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q  <= '0;
            data_q <= '0;
            last_q <= 1'b0;
            sat_q  <= 1'b0;
        end else if (accept) begin
            idx_q  <= '0;
            data_q <= cap_value;
            last_q <= 1'b0;
            sat_q  <= cap_sat;
        end else if (handshake) begin
            if (last_q) begin
                idx_q  <= '0;
                data_q <= '0;
                last_q <= 1'b0;
                sat_q  <= 1'b0;
            end else begin
                idx_q  <= idx_p1;
                data_q <= adv_value;
                last_q <= (idx_p1 == LAST_IDX);
                sat_q  <= adv_sat;
            end
        end
    end

    assign bus.cap_ack_o   = accept;
    assign bus.busy_o      = out_valid;
    assign bus.out_valid_o = out_valid;
    assign bus.out_data_o  = data_q;
    assign bus.out_idx_o   = idx_q;
    assign bus.out_last_o  = last_q;
    assign bus.out_sat_o   = sat_q;

endmodule

// File: tb/tb_mac_drain_requant.sv
// Self-checking bench for mac_drain_requant: directed scenarios plus a
// randomized run, all checked against an arithmetic reference of the
// requantization rule.
module tb_mac_drain_requant;
    import mac_pkg::*;

    localparam int N = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mac_drain_requant_if #(.LANES(N)) bus ();

    mac_drain_requant #(.LANES(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   n_checks = 0;
    int   n_pass   = 0;
    acc_t stim_a [N];
    acc_t stim_b [N];

    // Reference: round half-up, floor shift, clamp; returns {sat, data}.
    function automatic logic [8:0] ref_q(input acc_t x, input int s);
        longint v;
        v = longint'(x);
        if (s > 0) v = v + (longint'(1) << (s - 1));
        v = v >>> s;
        if (v > 127)  return {1'b1, 8'h7f};
        if (v < -128) return {1'b1, 8'h80};
        return {1'b0, v[7:0]};
    endfunction

    // Beat layout: {valid, idx, last, sat, data}.
    function automatic logic [13:0] exp_beat(input acc_t x, input int s, input int k);
        return {1'b1, 3'(k), (k == N - 1), ref_q(x, s)};
    endfunction

    function automatic logic [13:0] obs();
        return {bus.out_valid_o, bus.out_idx_o, bus.out_last_o, bus.out_sat_o, bus.out_data_o};
    endfunction

    function automatic acc_t rand_acc();
        case ($urandom_range(0, 2))
            0:       return acc_t'($urandom);
            1:       return acc_t'(int'($urandom_range(0, 800)) - 400);
            default: return acc_t'(int'($urandom_range(0, 200000)) - 100000);
        endcase
    endfunction

    task automatic fill_random(output acc_t a [N]);
        for (int i = 0; i < N; i++) a[i] = rand_acc();
    endtask

    task automatic drive_acc(input acc_t a [N]);
        for (int i = 0; i < N; i++) bus.acc_i[i*ACC_W +: ACC_W] = a[i];
    endtask

    // Present a capture for one cycle from idle; returns at the negedge where
    // lane 0 should be visible.
    task automatic start_capture(input acc_t a [N], input int s);
        @(negedge clk);
        drive_acc(a);
        bus.shift_i = 5'(s);
        bus.cap_i   = 1'b1;
        @(negedge clk);
        bus.cap_i   = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] o;
        rst = 1'b1;
        bus.cap_i = 1'b0;
        bus.shift_i = '0;
        bus.acc_i = '0;
        bus.out_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        o = {obs(), bus.busy_o, bus.cap_ack_o};
        n_checks++;
        if (o !== 16'h0) $display("FAIL reset_state: got %h expected %h", o, 16'h0);
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_shift0();
        int          exp_d   [N] = '{0, 1, -1, 127, 127, -128, -128, 127};
        bit          sat_tab [N] = '{0, 0, 0, 0, 1, 1, 0, 1};
        acc_t        a       [N] = '{0, 1, -1, 127, 128, -129, -128, 1000};
        logic [13:0] e, o;
        bus.out_ready_i = 1'b1;
        start_capture(a, 0);
        for (int k = 0; k < N; k++) begin
            e = {1'b1, 3'(k), (k == N - 1), sat_tab[k], 8'(exp_d[k])};
            o = obs();
            n_checks++;
            if (o !== e) $display("FAIL shift0 lane %0d: got %h expected %h", k, o, e);
            else n_pass++;
            @(negedge clk);
        end
        n_checks++;
        if ({bus.out_valid_o, bus.busy_o} !== 2'b00)
            $display("FAIL shift0_end valid/busy: got %b expected 00", {bus.out_valid_o, bus.busy_o});
        else n_pass++;
    endtask

    task automatic test_rounding();
        int          spot [4] = '{2, -1, 1, 0};
        logic [13:0] e, o;
        fill_random(stim_a);
        stim_a[0] = 24; stim_a[1] = -24; stim_a[2] = 8; stim_a[3] = 7;
        bus.out_ready_i = 1'b1;
        start_capture(stim_a, 4);
        for (int k = 0; k < N; k++) begin
            e = exp_beat(stim_a[k], 4, k);
            if (k < 4) e[7:0] = 8'(spot[k]);
            o = obs();
            n_checks++;
            if (o !== e) $display("FAIL round_s4 lane %0d: got %h expected %h", k, o, e);
            else n_pass++;
            @(negedge clk);
        end
        fill_random(stim_a);
        stim_a[0] = 32'sh7fffffff;
        stim_a[1] = 32'sh80000000;
        start_capture(stim_a, 31);
        for (int k = 0; k < N; k++) begin
            e = exp_beat(stim_a[k], 31, k);
            if (k == 0) e[7:0] = 8'd1;
            o = obs();
            n_checks++;
            if (o !== e) $display("FAIL round_s31 lane %0d: got %h expected %h", k, o, e);
            else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        int          k = 0, stall = 0, s;
        logic [13:0] e, o;
        fill_random(stim_a);
        s = $urandom_range(0, 31);
        bus.out_ready_i = 1'b1;
        start_capture(stim_a, s);
        for (int cyc = 0; cyc < 11; cyc++) begin
            e = exp_beat(stim_a[k], s, k);
            o = obs();
            n_checks++;
            if (o !== e) $display("FAIL backpressure cycle %0d: got %h expected %h", cyc, o, e);
            else n_pass++;
            if (k == 2 && stall < 3) begin
                bus.out_ready_i = 1'b0;
                stall++;
            end else begin
                bus.out_ready_i = 1'b1;
                k++;
            end
            @(negedge clk);
        end
        n_checks++;
        if ({bus.out_valid_o, bus.busy_o} !== 2'b00)
            $display("FAIL backpressure_end valid/busy: got %b expected 00", {bus.out_valid_o, bus.busy_o});
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int          sa, sb;
        logic [13:0] e, o;
        fill_random(stim_a);
        fill_random(stim_b);
        sa = $urandom_range(0, 31);
        sb = $urandom_range(0, 31);
        bus.out_ready_i = 1'b1;
        @(negedge clk);
        drive_acc(stim_a);
        bus.shift_i = 5'(sa);
        bus.cap_i   = 1'b1;
        @(negedge clk);
        drive_acc(stim_b);
        bus.shift_i = 5'(sb);
        for (int k = 0; k < N; k++) begin
            e = exp_beat(stim_a[k], sa, k);
            o = obs();
            n_checks++;
            if (o !== e) $display("FAIL b2b_first lane %0d: got %h expected %h", k, o, e);
            else n_pass++;
            #1;
            n_checks++;
            if (bus.cap_ack_o !== (k == N - 1))
                $display("FAIL b2b_cap_ack lane %0d: got %b expected %b", k, bus.cap_ack_o, (k == N - 1));
            else n_pass++;
            @(negedge clk);
        end
        bus.cap_i = 1'b0;
        for (int k = 0; k < N; k++) begin
            e = exp_beat(stim_b[k], sb, k);
            o = obs();
            n_checks++;
            if (o !== e) $display("FAIL b2b_second lane %0d: got %h expected %h", k, o, e);
            else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_drain();
        int          s;
        logic [13:0] e, o;
        fill_random(stim_a);
        s = $urandom_range(0, 31);
        bus.out_ready_i = 1'b1;
        start_capture(stim_a, s);
        repeat (4) @(negedge clk);
        e = exp_beat(stim_a[4], s, 4);
        o = obs();
        n_checks++;
        if (o !== e) $display("FAIL midrst_pre lane 4: got %h expected %h", o, e);
        else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({obs(), bus.busy_o} !== 15'h0)
            $display("FAIL midrst_outputs: got %h expected %h", {obs(), bus.busy_o}, 15'h0);
        else n_pass++;
        fill_random(stim_a);
        s = $urandom_range(0, 31);
        start_capture(stim_a, s);
        for (int k = 0; k < N; k++) begin
            e = exp_beat(stim_a[k], s, k);
            o = obs();
            n_checks++;
            if (o !== e) $display("FAIL midrst_after lane %0d: got %h expected %h", k, o, e);
            else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_idle_hold();
        int          s;
        logic [13:0] e, o;
        fill_random(stim_a);
        fill_random(stim_b);
        s = $urandom_range(0, 31);
        bus.out_ready_i = 1'b0;
        start_capture(stim_a, s);
        for (int c = 0; c < 5; c++) begin
            e = exp_beat(stim_a[0], s, 0);
            o = obs();
            n_checks++;
            if (o !== e) $display("FAIL hold cycle %0d: got %h expected %h", c, o, e);
            else n_pass++;
            drive_acc(stim_b);
            bus.shift_i = 5'($urandom_range(0, 31));
            bus.cap_i   = 1'b1;
            #1;
            n_checks++;
            if (bus.cap_ack_o !== 1'b0) $display("FAIL hold_cap_ack cycle %0d: got %b expected 0", c, bus.cap_ack_o);
            else n_pass++;
            @(negedge clk);
        end
        bus.cap_i = 1'b0;
        bus.out_ready_i = 1'b1;
        for (int k = 0; k < N; k++) begin
            e = exp_beat(stim_a[k], s, k);
            o = obs();
            n_checks++;
            if (o !== e) $display("FAIL hold_drain lane %0d: got %h expected %h", k, o, e);
            else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        int          s, k, budget;
        logic [13:0] e, o;
        for (int it = 0; it < 20; it++) begin
            fill_random(stim_a);
            s = $urandom_range(0, 31);
            bus.out_ready_i = 1'b1;
            start_capture(stim_a, s);
            k = 0;
            budget = 0;
            while (k < N && budget < 200) begin
                e = exp_beat(stim_a[k], s, k);
                o = obs();
                n_checks++;
                if (o !== e) $display("FAIL random it %0d lane %0d: got %h expected %h", it, k, o, e);
                else n_pass++;
                bus.out_ready_i = ($urandom_range(0, 3) != 0);
                if (bus.out_ready_i) k++;
                budget++;
                @(negedge clk);
            end
            if (k < N) begin
                n_checks++;
                $display("FAIL random_timeout it %0d: reached lane %0d expected %0d", it, k, N);
            end
        end
    endtask

    initial begin
        test_reset();
        test_shift0();
        test_rounding();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_drain();
        test_idle_hold();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
